spi_cmd_decoder: RTL and testbench
==================================

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 25175, inter-byte timeout in clk cycles (~1 ms at 25.175 MHz).
REQ-002 Parameter MAX_X, default 639, largest legal x coordinate.
REQ-003 Parameter MAX_Y, default 479, largest legal y coordinate.
REQ-004 clk  input  1  25.175 MHz pixel clock from the system PLL; sole clock.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 rx_byte  input  8  received SPI byte, already synchronised to clk.
REQ-007 rx_valid  input  1  one-cycle strobe qualifying rx_byte.
REQ-008 cmd_valid  output  1  decoded draw command available.
REQ-009 cmd_ready  input  1  downstream pixel store accepts command.
REQ-010 cmd_x  output  10  pixel column.
REQ-011 cmd_y  output  10  pixel row.
REQ-012 cmd_color  output  3  colour code written to pixel store.
REQ-013 cmd_brush  output  1  1 = paint, 0 = erase/no-op.
REQ-014 err_count  output  8  saturating count of dropped packets.
REQ-015 overflow  output  1  sticky: a valid packet was lost because output was occupied.

Function
REQ-016 Packet is 4 bytes: B0 = {4'hA sync, brush, color[2:0]}; B1 = x[9:2]; B2 = {x[1:0], y[9:4]}; B3 = {y[3:0], chk[3:0]}.
REQ-017 chk SHALL equal XOR of the six nibbles of B0, B1, B2 plus nibble y[3:0].
REQ-018 FSM states: HDR, GOT0, GOT1, GOT2; each rx_valid advances one state; GOT2 plus rx_valid returns to HDR.
REQ-019 In HDR, a byte whose upper nibble is not 4'hA is discarded, state stays HDR, err_count increments.
REQ-020 Timeout counter clears on every rx_valid; reaching TIMEOUT_CYCLES in GOT0/GOT1/GOT2 returns to HDR, discards partial packet, increments err_count.
REQ-021 Counter idle (no count) in HDR.
REQ-022 On B3 receipt: checksum mismatch, x > MAX_X or y > MAX_Y drops packet and increments err_count.
REQ-023 Valid packet loads cmd_* and asserts cmd_valid the cycle after the B3 rx_valid (latency 1).
REQ-024 cmd_valid and cmd_* SHALL hold stable until the cycle cmd_valid && cmd_ready; cmd_valid deasserts next cycle unless a new packet loads that same cycle.
REQ-025 Valid packet completing while cmd_valid=1 and cmd_ready=0: new packet dropped, old command retained, overflow set, err_count increments.
REQ-026 Valid packet completing in the same cycle as handshake: new command loads, cmd_valid stays 1.
REQ-027 Byte reception continues regardless of cmd_valid/cmd_ready.
REQ-028 err_count saturates at 8'hFF; simultaneous error sources in one cycle count once.
REQ-029 overflow clears only on reset.

Reset
REQ-030 reset_n=0 at a clk edge: state HDR, timeout counter 0, cmd_valid 0, cmd_x 0, cmd_y 0, cmd_color 0, cmd_brush 0, err_count 0, overflow 0.
REQ-031 Reset mid-packet discards partial bytes; first byte after release is treated as B0.
REQ-032 rx_valid asserted during reset is ignored.

Structure
REQ-033 Shared package holds state enum, SYNC_NIBBLE (4'hA), packet byte count (4) and draw-command struct {x, y, color, brush}.
REQ-034 One sub-module natural: cmd_timeout (loadable timeout counter with clear and expiry flag).

Verification
REQ-035 Send A5, 64, 0B, 7x with correct chk, cmd_ready=1 -> cmd_valid one cycle later, x=400, y=183 (from bytes), color=5, brush=0.
REQ-036 Send 3F then valid packet -> err_count=1, valid packet decoded normally.
REQ-037 Send A5, 64 then idle 25175 cycles, then full packet -> err_count=1, only full packet emitted.
REQ-038 Packet with x=640 or bad chk -> no cmd_valid, err_count increments.
REQ-039 cmd_ready=0, two back-to-back valid packets -> first held stable, overflow=1, err_count=1; raise cmd_ready -> one handshake only.
REQ-040 Assert reset_n=0 after B1, release, send full packet -> exactly one command, all counters 0 except as produced.

Source files
------------

// File: rtl/spi_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_decoder_pkg
// Description : Shared types and constants for the SPI draw-command decoder.
// Revision    : 1.0  initial release
// ============================================================================
package spi_cmd_decoder_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        GOT0 = 2'd1,
        GOT1 = 2'd2,
        GOT2 = 2'd3
    } state_e;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;
    localparam int         PKT_BYTES   = 4;
    localparam int         COORD_W     = 10;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [2:0]         color;
        logic               brush;
    } draw_cmd_t;

    // Packet checksum: XOR of the six nibbles of B0..B2 and the low y nibble.
    function automatic logic [3:0] pkt_chk(input logic [7:0] b0,
                                           input logic [7:0] b1,
                                           input logic [7:0] b2,
                                           input logic [3:0] y_lo);
        return b0[7:4] ^ b0[3:0] ^ b1[7:4] ^ b1[3:0] ^ b2[7:4] ^ b2[3:0] ^ y_lo;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_decoder_if
// Description : Byte input and draw-command output bundle of the decoder.
// Revision    : 1.0  initial release
// ============================================================================
interface spi_cmd_decoder_if;
    import spi_cmd_decoder_pkg::*;

    logic [7:0]         rx_byte;
    logic               rx_valid;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [COORD_W-1:0] cmd_x;
    logic [COORD_W-1:0] cmd_y;
    logic [2:0]         cmd_color;
    logic               cmd_brush;
    logic [7:0]         err_count;
    logic               overflow;

    // Byte source and command sink side
    modport master (
        output rx_byte, rx_valid, cmd_ready,
        input  cmd_valid, cmd_x, cmd_y, cmd_color, cmd_brush, err_count, overflow
    );

    // Decoder side
    modport slave (
        input  rx_byte, rx_valid, cmd_ready,
        output cmd_valid, cmd_x, cmd_y, cmd_color, cmd_brush, err_count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/spi_cmd_decoder_cmd_timeout.sv
`default_nettype none
// ============================================================================
// Module      : cmd_timeout
// Description : Inter-byte timeout counter with synchronous clear and a
//               level expiry flag that stays set until cleared.
// Revision    : 1.0  initial release
// ============================================================================
module cmd_timeout
    import spi_cmd_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 25175
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic clear,
    input  wire logic enable,
    output logic      expired
);
    localparam int               CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Count idle cycles, saturating at the limit so the flag stays asserted
    always_ff @(posedge clk) begin
        if (!reset_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && (count != LIMIT))
            count <= count + 1'b1;
    end

    assign expired = (count == LIMIT);
endmodule
`default_nettype wire

// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : spi_cmd_decoder
// Description : Assembles 4-byte SPI draw packets, validates sync, checksum
//               and coordinate range, and presents one held draw command
//               with a valid/ready handshake.
// Revision    : 1.0  initial release
// ============================================================================
module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 25175,
    parameter int MAX_X          = 639,
    parameter int MAX_Y          = 479
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    spi_cmd_decoder_if.slave bus
);
    localparam logic [1:0] ST_HDR  = HDR;
    localparam logic [1:0] ST_GOT0 = GOT0;
    localparam logic [1:0] ST_GOT1 = GOT1;
    localparam logic [1:0] ST_GOT2 = GOT2;

    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(MAX_X);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(MAX_Y);

    logic [1:0]         state;
    logic [7:0]         hold [PKT_BYTES-1];
    logic               expired;
    logic [COORD_W-1:0] pkt_x;
    logic [COORD_W-1:0] pkt_y;
    logic               pkt_done;
    logic               pkt_ok;
    logic               good_pkt;
    logic               handshake;
    logic               load;
    logic               sync_err;
    logic               tmo_err;
    logic               ovf_evt;
    logic               err_evt;
    draw_cmd_t          cmd_q;
    logic               cmd_valid_q;
    logic [7:0]         err_q;
    logic               ovf_q;

    cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (bus.rx_valid || (state == ST_HDR)),
        .enable  (state != ST_HDR),
        .expired (expired)
    );

    // Packet decode, validation and error-event collection
    always_comb begin
        pkt_x     = {hold[1], hold[2][7:6]};
        pkt_y     = {hold[2][5:0], bus.rx_byte[7:4]};
        pkt_done  = bus.rx_valid && (state == ST_GOT2);
        pkt_ok    = (pkt_chk(hold[0], hold[1], hold[2], bus.rx_byte[7:4]) == bus.rx_byte[3:0])
                    && (pkt_x <= X_LIM) && (pkt_y <= Y_LIM);
        good_pkt  = pkt_done && pkt_ok;
        handshake = cmd_valid_q && bus.cmd_ready;
        load      = good_pkt && (!cmd_valid_q || handshake);
        ovf_evt   = good_pkt && cmd_valid_q && !bus.cmd_ready;
        sync_err  = bus.rx_valid && (state == ST_HDR) && (bus.rx_byte[7:4] != SYNC_NIBBLE);
        tmo_err   = !bus.rx_valid && (state != ST_HDR) && expired;
        err_evt   = sync_err || tmo_err || (pkt_done && !pkt_ok) || ovf_evt;
    end

    // Packet framing FSM; a received byte takes priority over an expiring timer
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_HDR;
        end else begin
            case (state)
                ST_HDR:  if (bus.rx_valid && !sync_err) state <= ST_GOT0;
                ST_GOT0: if (bus.rx_valid) state <= ST_GOT1; else if (expired) state <= ST_HDR;
                ST_GOT1: if (bus.rx_valid) state <= ST_GOT2; else if (expired) state <= ST_HDR;
                ST_GOT2: if (bus.rx_valid || expired) state <= ST_HDR;
                default: state <= ST_HDR;
            endcase
        end
    end

    // Capture B0..B2 while the packet is being assembled
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < PKT_BYTES - 1; i++) hold[i] <= '0;
        end else if (bus.rx_valid) begin
            case (state)
                ST_HDR:  hold[0] <= bus.rx_byte;
                ST_GOT0: hold[1] <= bus.rx_byte;
                ST_GOT1: hold[2] <= bus.rx_byte;
                default: ;
            endcase
        end
    end

    // Output command register: loads when free or being consumed this cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
        end else if (load) begin
            cmd_q.x     <= pkt_x;
            cmd_q.y     <= pkt_y;
            cmd_q.color <= hold[0][2:0];
            cmd_q.brush <= hold[0][3];
            cmd_valid_q <= 1'b1;
        end else if (handshake) begin
            cmd_valid_q <= 1'b0;
        end
    end

    // Saturating drop counter and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (err_evt && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
            if (ovf_evt) ovf_q <= 1'b1;
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_x     = cmd_q.x;
    assign bus.cmd_y     = cmd_q.y;
    assign bus.cmd_color = cmd_q.color;
    assign bus.cmd_brush = cmd_q.brush;
    assign bus.err_count = err_q;
    assign bus.overflow  = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_cmd_decoder
// Description : Self-checking bench: directed packets plus random traffic
//               compared every cycle against a byte-queue reference model.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_cmd_decoder;
    localparam int T_CYC = 25175;
    localparam int MAX_X = 639;
    localparam int MAX_Y = 479;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #20 clk = ~clk;

    spi_cmd_decoder_if bus();

    spi_cmd_decoder #(
        .TIMEOUT_CYCLES (T_CYC),
        .MAX_X          (MAX_X),
        .MAX_Y          (MAX_Y)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int         total = 0;
    int         bad   = 0;
    longint     cyc   = 0;
    longint     last_byte = 0;
    logic [7:0] pq [$];
    logic       m_valid = 1'b0;
    int         m_x = 0, m_y = 0, m_color = 0, m_brush = 0;
    int         m_err = 0;
    logic       m_ovf = 1'b0;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: bytes accumulate in a queue; a full queue is judged
    // against the packet rules; the held command is a single slot.
    task automatic model_edge(input logic rv, input logic [7:0] b, input logic rdy);
        logic       hs, err, got;
        int         nx, ny, ncol, nbr, chk;
        hs = m_valid && rdy; err = 1'b0; got = 1'b0;
        nx = 0; ny = 0; ncol = 0; nbr = 0;
        if (rv) begin
            last_byte = cyc;
            if (pq.size() == 0 && (b >> 4) != 8'hA) begin
                err = 1'b1;
            end else begin
                pq.push_back(b);
                if (pq.size() == 4) begin
                    chk = 0;
                    for (int i = 0; i < 3; i++) chk = chk ^ (pq[i] >> 4) ^ (pq[i] & 15);
                    chk = chk ^ (pq[3] >> 4);
                    nx   = pq[1] * 4 + (pq[2] >> 6);
                    ny   = (pq[2] & 63) * 16 + (pq[3] >> 4);
                    ncol = pq[0] & 7;
                    nbr  = (pq[0] >> 3) & 1;
                    if (chk == (pq[3] & 15) && nx <= MAX_X && ny <= MAX_Y) got = 1'b1;
                    else err = 1'b1;
                    pq.delete();
                end
            end
        end else if (pq.size() > 0 && (cyc - last_byte) > T_CYC) begin
            pq.delete();
            err = 1'b1;
        end
        if (got) begin
            if (!m_valid || hs) begin
                m_valid = 1'b1; m_x = nx; m_y = ny; m_color = ncol; m_brush = nbr;
            end else begin
                m_ovf = 1'b1; err = 1'b1;
            end
        end else if (hs) begin
            m_valid = 1'b0;
        end
        if (err && m_err < 255) m_err++;
    endtask

    task automatic tick(input logic rv, input logic [7:0] b, input logic rdy);
        @(negedge clk);
        bus.rx_valid  = rv;
        bus.rx_byte   = b;
        bus.cmd_ready = rdy;
        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            pq.delete(); m_valid = 1'b0; m_x = 0; m_y = 0; m_color = 0; m_brush = 0;
            m_err = 0; m_ovf = 1'b0;
        end else begin
            model_edge(rv, b, rdy);
        end
        #1;
        check("cmd_valid", bus.cmd_valid, m_valid);
        if (m_valid) begin
            check("cmd_x", bus.cmd_x, m_x);
            check("cmd_y", bus.cmd_y, m_y);
            check("cmd_color", bus.cmd_color, m_color);
            check("cmd_brush", bus.cmd_brush, m_brush);
        end
        check("err_count", bus.err_count, m_err);
        check("overflow", bus.overflow, m_ovf);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, rdy);
    endtask

    function automatic logic [31:0] mk_pkt(input logic brush, input logic [2:0] color,
                                           input logic [9:0] x, input logic [9:0] y,
                                           input logic [3:0] flip);
        logic [7:0] b0, b1, b2;
        logic [3:0] c;
        b0 = {4'hA, brush, color};
        b1 = x[9:2];
        b2 = {x[1:0], y[9:4]};
        c  = b0[7:4] ^ b0[3:0] ^ b1[7:4] ^ b1[3:0] ^ b2[7:4] ^ b2[3:0] ^ y[3:0] ^ flip;
        return {b0, b1, b2, y[3:0], c};
    endfunction

    task automatic send_pkt(input logic [31:0] p, input logic rdy);
        for (int i = 3; i >= 0; i--) tick(1'b1, p[i*8 +: 8], rdy);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b1, 8'hA5, 1'b1);
        reset_n = 1'b1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        logic [9:0]  rx, ry;
        logic [3:0]  fl;
        bus.rx_valid = 1'b0; bus.rx_byte = 8'h00; bus.cmd_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", bus.cmd_valid, 0);
        check("rst_x", bus.cmd_x, 0);
        check("rst_y", bus.cmd_y, 0);
        check("rst_color", bus.cmd_color, 0);
        check("rst_brush", bus.cmd_brush, 0);
        check("rst_err", bus.err_count, 0);
        check("rst_ovf", bus.overflow, 0);

        // Reference packet A5 64 0B 71
        tick(1'b1, 8'hA5, 1'b1); tick(1'b1, 8'h64, 1'b1);
        tick(1'b1, 8'h0B, 1'b1); tick(1'b1, 8'h71, 1'b1);
        check("ref_valid", bus.cmd_valid, 1);
        check("ref_x", bus.cmd_x, 400);
        check("ref_y", bus.cmd_y, 183);
        check("ref_color", bus.cmd_color, 5);
        check("ref_brush", bus.cmd_brush, 0);
        idle(2, 1'b1);

        // Bad sync byte followed by a good packet
        do_reset();
        tick(1'b1, 8'h3F, 1'b1);
        send_pkt(mk_pkt(1'b1, 3'd2, 10'd17, 10'd33, 4'h0), 1'b1);
        check("sync_err", bus.err_count, 1);
        check("sync_valid", bus.cmd_valid, 1);
        idle(2, 1'b1);

        // Partial packet abandoned by timeout
        do_reset();
        tick(1'b1, 8'hA5, 1'b1); tick(1'b1, 8'h64, 1'b1);
        idle(T_CYC + 2, 1'b1);
        check("tmo_err", bus.err_count, 1);
        send_pkt(mk_pkt(1'b0, 3'd7, 10'd5, 10'd6, 4'h0), 1'b1);
        check("tmo_valid", bus.cmd_valid, 1);
        idle(2, 1'b1);

        // Gap just inside the timeout keeps the packet alive
        do_reset();
        p = mk_pkt(1'b1, 3'd1, 10'd300, 10'd200, 4'h0);
        tick(1'b1, p[31:24], 1'b1);
        idle(T_CYC - 1, 1'b1);
        tick(1'b1, p[23:16], 1'b1); tick(1'b1, p[15:8], 1'b1); tick(1'b1, p[7:0], 1'b1);
        check("gap_valid", bus.cmd_valid, 1);
        check("gap_err", bus.err_count, 0);
        idle(2, 1'b1);

        // Range and checksum rejects, then the legal corner
        do_reset();
        send_pkt(mk_pkt(1'b1, 3'd3, 10'd640, 10'd10, 4'h0), 1'b1);
        check("x640_valid", bus.cmd_valid, 0);
        check("x640_err", bus.err_count, 1);
        send_pkt(mk_pkt(1'b1, 3'd3, 10'd10, 10'd10, 4'h6), 1'b1);
        check("chk_err", bus.err_count, 2);
        send_pkt(mk_pkt(1'b1, 3'd3, 10'd10, 10'd480, 4'h0), 1'b1);
        check("y480_err", bus.err_count, 3);
        send_pkt(mk_pkt(1'b1, 3'd6, 10'd639, 10'd479, 4'h0), 1'b1);
        check("corner_valid", bus.cmd_valid, 1);
        check("corner_x", bus.cmd_x, 639);
        idle(2, 1'b1);

        // Overflow: two good packets while the sink is stalled
        do_reset();
        send_pkt(mk_pkt(1'b1, 3'd4, 10'd10, 10'd11, 4'h0), 1'b0);
        send_pkt(mk_pkt(1'b0, 3'd2, 10'd20, 10'd21, 4'h0), 1'b0);
        check("ovf_x_held", bus.cmd_x, 10);
        check("ovf_flag", bus.overflow, 1);
        check("ovf_err", bus.err_count, 1);
        tick(1'b0, 8'h00, 1'b1);
        check("ovf_one_hs", bus.cmd_valid, 0);
        idle(2, 1'b1);

        // Load in the same cycle as the handshake
        do_reset();
        send_pkt(mk_pkt(1'b1, 3'd4, 10'd50, 10'd51, 4'h0), 1'b0);
        p = mk_pkt(1'b0, 3'd1, 10'd60, 10'd61, 4'h0);
        tick(1'b1, p[31:24], 1'b0); tick(1'b1, p[23:16], 1'b0); tick(1'b1, p[15:8], 1'b0);
        tick(1'b1, p[7:0], 1'b1);
        check("hs_load_valid", bus.cmd_valid, 1);
        check("hs_load_x", bus.cmd_x, 60);
        check("hs_load_ovf", bus.overflow, 0);
        idle(2, 1'b1);

        // Reset mid-packet
        tick(1'b1, 8'hA5, 1'b1); tick(1'b1, 8'h64, 1'b1);
        do_reset();
        send_pkt(mk_pkt(1'b1, 3'd5, 10'd100, 10'd101, 4'h0), 1'b1);
        check("midrst_valid", bus.cmd_valid, 1);
        check("midrst_err", bus.err_count, 0);
        idle(2, 1'b1);

        // Random traffic with random sink back-pressure
        do_reset();
        for (int n = 0; n < 250; n++) begin
            rx = 10'($urandom_range(0, MAX_X));
            ry = 10'($urandom_range(0, MAX_Y));
            fl = 4'h0;
            case ($urandom_range(0, 9))
                0: fl = 4'($urandom_range(1, 15));
                1: rx = 10'($urandom_range(MAX_X + 1, 1023));
                2: ry = 10'($urandom_range(MAX_Y + 1, 1023));
                3: tick(1'b1, 8'($urandom_range(0, 9) << 4), ($urandom_range(0, 3) != 0));
                default: ;
            endcase
            p = mk_pkt(1'($urandom), 3'($urandom), rx, ry, fl);
            for (int i = 3; i >= 0; i--) begin
                tick(1'b1, p[i*8 +: 8], ($urandom_range(0, 3) != 0));
                idle($urandom_range(0, 2), ($urandom_range(0, 3) != 0));
            end
        end
        idle(4, 1'b1);

        // err_count saturation
        do_reset();
        for (int i = 0; i < 260; i++) tick(1'b1, 8'h00, 1'b1);
        check("err_sat", bus.err_count, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
